// File: rtl/mux_pipe_reg.sv
// N-input operand select mux feeding a STAGES-deep valid-tracked pipeline.
// Stall/flush come from the hazard unit; sel_err flags out-of-range selects.
module mux_pipe_reg #(
    parameter int WIDTH  = 8,
    parameter int N_IN   = 4,
    parameter int SEL_W  = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        occupancy,
    output logic                    sel_err
);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vld_n;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [WIDTH-1:0]  mux_data;
    logic              sel_ok;
    logic              accept;
    logic              v0;
    logic [WIDTH-1:0]  d0;

    function automatic logic [CNT_W-1:0] popcnt(
        input logic [STAGES-1:0] v
    );
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < STAGES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign accept = !stall && !flush;
    assign sel_ok = (32'(sel) < 32'(N_IN));

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Invalid slots always carry zero data so bubbles read back as 0.
    assign v0 = in_valid && sel_ok;
    assign d0 = v0 ? mux_data : '0;

    always_comb begin
        vld_n = vld;
        if (flush) begin
            vld_n = '0;
        end else if (!stall) begin
            vld_n[0] = v0;
            for (int k = 1; k < STAGES; k++) begin
                vld_n[k] = vld[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            occupancy <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat[k] <= '0;
            end
        end else begin
            vld       <= vld_n;
            occupancy <= popcnt(vld_n);
            if (flush) begin
                for (int k = 0; k < STAGES; k++) begin
                    dat[k] <= '0;
                end
            end else if (!stall) begin
                dat[0] <= d0;
                for (int k = 1; k < STAGES; k++) begin
                    dat[k] <= dat[k-1];
                end
            end
        end
    end

    // Set beats clear when both happen on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (accept && in_valid && !sel_ok) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    assign out_data  = dat[STAGES-1];
    assign out_valid = vld[STAGES-1];

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Scoreboard bench for mux_pipe_reg: a 4-input and a 3-input instance
// share control stimulus; each queued expectation names the instance.
module tb_mux_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din_a;
    logic [23:0] din_b;
    logic [1:0]  sel;
    logic        iv, st, fl, clr;

    logic [7:0]  a_d, b_d;
    logic        a_v, b_v, a_err, b_err;
    logic [1:0]  a_occ, b_occ;

    always #5 clk = ~clk;

    mux_pipe_reg #(.WIDTH(8), .N_IN(4), .SEL_W(2),
                   .STAGES(2), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(din_a), .sel(sel),
        .in_valid(iv), .stall(st), .flush(fl), .err_clr(clr),
        .out_data(a_d), .out_valid(a_v), .occupancy(a_occ),
        .sel_err(a_err)
    );

    mux_pipe_reg #(.WIDTH(8), .N_IN(3), .SEL_W(2),
                   .STAGES(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(din_b), .sel(sel),
        .in_valid(iv), .stall(st), .flush(fl), .err_clr(clr),
        .out_data(b_d), .out_valid(b_v), .occupancy(b_occ),
        .sel_err(b_err)
    );

    typedef struct {
        bit         dut;
        logic       v;
        logic [7:0] d;
        logic [1:0] occ;
        logic       err;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Packed view: {valid, data, occupancy, sel_err}
    task automatic check(string nm, logic [11:0] got, logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got v=%b d=%h occ=%0d err=%b, need v=%b d=%h occ=%0d err=%b",
                     nm, got[11], got[10:3], got[2:1], got[0],
                     exp[11], exp[10:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic step(bit dut, logic [1:0] s, logic i, logic t,
                        logic f, logic c, logic ev, logic [7:0] ed,
                        logic [1:0] eo, logic ee, string nm);
        exp_t e;
        @(negedge clk);
        sel = s; iv = i; st = t; fl = f; clr = c;
        e.dut = dut; e.v = ev; e.d = ed; e.occ = eo; e.err = ee;
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: each expectation describes outputs after the next edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut)
                check(e.name, {b_v, b_d, b_occ, b_err},
                      {e.v, e.d, e.occ, e.err});
            else
                check(e.name, {a_v, a_d, a_occ, a_err},
                      {e.v, e.d, e.occ, e.err});
        end
    end

    initial begin
        rst_n = 1'b0;
        sel = 2'd0; iv = 1'b0; st = 1'b0; fl = 1'b0; clr = 1'b0;
        din_a = {8'h12, 8'hFF, 8'h5A, 8'hA5};
        din_b = {8'h33, 8'h22, 8'h11};
        #1;
        check("reset0_a", {a_v, a_d, a_occ, a_err}, 12'h000);
        check("reset0_b", {b_v, b_d, b_occ, b_err}, 12'h000);
        #12 rst_n = 1'b1;

        // Select sweep
        step(0, 2'd0, 1, 0, 0, 0, 0, 8'h00, 2'd1, 0, "sweep_fill");
        step(0, 2'd1, 1, 0, 0, 0, 1, 8'hA5, 2'd2, 0, "sweep_ch0");
        step(0, 2'd2, 1, 0, 0, 0, 1, 8'h5A, 2'd2, 0, "sweep_ch1");
        step(0, 2'd3, 1, 0, 0, 0, 1, 8'hFF, 2'd2, 0, "sweep_ch2");
        @(negedge clk);
        din_a = {8'h12, 8'hFF, 8'hBE, 8'hDE};
        q.push_back('{0, 1'b1, 8'h12, 2'd2, 1'b0, "sweep_ch3"});
        sel = 2'd0;

        // Stall with DE at output and BE in stage 0
        step(0, 2'd1, 1, 0, 0, 0, 1, 8'hDE, 2'd2, 0, "stall_pre");
        step(0, 2'd2, 1, 1, 0, 0, 1, 8'hDE, 2'd2, 0, "stall_c1");
        step(0, 2'd2, 1, 1, 0, 0, 1, 8'hDE, 2'd2, 0, "stall_c2");
        step(0, 2'd2, 1, 1, 0, 0, 1, 8'hDE, 2'd2, 0, "stall_c3");
        step(0, 2'd2, 0, 0, 0, 0, 1, 8'hBE, 2'd1, 0, "stall_be");
        step(0, 2'd2, 0, 0, 0, 0, 0, 8'h00, 2'd0, 0, "stall_drain");

        // Flush beats stall and in_valid
        step(0, 2'd0, 1, 0, 0, 0, 0, 8'h00, 2'd1, 0, "flush_f1");
        step(0, 2'd1, 1, 0, 0, 0, 1, 8'hDE, 2'd2, 0, "flush_f2");
        step(0, 2'd2, 1, 1, 1, 0, 0, 8'h00, 2'd0, 0, "flush_edge");
        step(0, 2'd2, 0, 0, 0, 0, 0, 8'h00, 2'd0, 0, "flush_gone1");
        step(0, 2'd2, 0, 0, 0, 0, 0, 8'h00, 2'd0, 0, "flush_gone2");

        // Bubbles
        @(negedge clk);
        din_a = {8'h12, 8'hFF, 8'h34, 8'hDE};
        q.push_back('{0, 1'b0, 8'h00, 2'd0, 1'b0, "bub_idle"});
        step(0, 2'd1, 1, 0, 0, 0, 0, 8'h00, 2'd1, 0, "bub_0");
        step(0, 2'd1, 0, 0, 0, 0, 1, 8'h34, 2'd1, 0, "bub_1");
        step(0, 2'd1, 1, 0, 0, 0, 0, 8'h00, 2'd1, 0, "bub_2");
        step(0, 2'd1, 0, 0, 0, 0, 1, 8'h34, 2'd1, 0, "bub_3");
        step(0, 2'd1, 1, 0, 0, 0, 0, 8'h00, 2'd1, 0, "bub_4");
        step(0, 2'd1, 0, 0, 0, 0, 1, 8'h34, 2'd1, 0, "bub_5");
        step(0, 2'd1, 0, 0, 0, 0, 0, 8'h00, 2'd0, 0, "bub_6");

        // Mid-stream asynchronous reset
        step(0, 2'd1, 1, 0, 0, 0, 0, 8'h00, 2'd1, 0, "rst_fill1");
        step(0, 2'd1, 1, 0, 0, 0, 1, 8'h34, 2'd2, 0, "rst_fill2");
        @(posedge clk);
        #3;
        iv = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async_a", {a_v, a_d, a_occ, a_err}, 12'h000);
        check("rst_async_b", {b_v, b_d, b_occ, b_err}, 12'h000);
        #2 rst_n = 1'b1;
        step(0, 2'd1, 0, 0, 0, 0, 0, 8'h00, 2'd0, 0, "rst_after");

        // Range errors on the 3-input instance
        step(1, 2'd3, 1, 0, 0, 0, 0, 8'h00, 2'd0, 1, "rng_bad");
        step(1, 2'd0, 1, 0, 0, 0, 0, 8'h00, 2'd1, 1, "rng_slot");
        step(1, 2'd0, 0, 0, 0, 0, 1, 8'h11, 2'd1, 1, "rng_good");
        step(1, 2'd0, 0, 0, 0, 0, 0, 8'h00, 2'd0, 1, "rng_sticky");
        step(1, 2'd0, 0, 0, 0, 1, 0, 8'h00, 2'd0, 0, "rng_clr");
        step(1, 2'd3, 1, 0, 0, 1, 0, 8'h00, 2'd0, 1, "rng_setwins");
        step(1, 2'd0, 0, 0, 1, 0, 0, 8'h00, 2'd0, 1, "rng_flushkeep");
        step(1, 2'd3, 1, 1, 0, 1, 0, 8'h00, 2'd0, 0, "rng_stallclr");
        step(1, 2'd3, 1, 1, 0, 0, 0, 8'h00, 2'd0, 0, "rng_stallign");
        step(1, 2'd3, 1, 0, 1, 0, 0, 8'h00, 2'd0, 0, "rng_flushign");
        step(1, 2'd2, 1, 0, 0, 0, 0, 8'h00, 2'd1, 0, "rng_top_ok");
        step(1, 2'd2, 0, 0, 0, 0, 1, 8'h33, 2'd1, 0, "rng_top_out");

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_pipe_reg.md
# mux_pipe_reg

Parametrised N-input, WIDTH-bit source-select multiplexer followed by a STAGES-deep pipeline register chain with valid tracking, stall, flush and range checking. It generalises the 8-bit two-input mux into a registered pipeline-stage operand selector. Typical use: the forwarding and operand-select point between pipeline stages of the CPU. Its stall and flush inputs connect to the hazard unit.

## Interface
- WIDTH, 8, data width per channel (>=1)
- N_IN, 4, number of input channels (>=2)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN
- STAGES, 2, pipeline depth in registers (1..8)
- CNT_W, 2, occupancy width; must satisfy 2**CNT_W > STAGES

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  N_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select
- in_valid  in  1  input item present this cycle
- stall  in  1  freeze all stages
- flush  in  1  invalidate all stages
- err_clr  in  1  clear sticky error
- out_data  out  WIDTH  last-stage data; 0 whenever out_valid=0
- out_valid  out  1  last-stage valid
- occupancy  out  CNT_W  number of valid stages, 0..STAGES
- sel_err  out  1  sticky: an out-of-range select was accepted

## Operation
- Each stage k holds (valid_k, data_k). Stage 0 is fed by the mux. Stage k+1 is fed by stage k. out_* is stage STAGES-1.
- Accept condition: stall=0 and flush=0. On accept, every stage shifts one position.
- Stage 0 loads as follows:
  - valid0 = in_valid & (sel < N_IN).
  - data0 = in_data channel sel when valid0, else 0.
- Data in invalid stages is always 0. Bubbles propagate as zero data.
- Out-of-range select: in_valid=1 and sel >= N_IN on an accept edge.
  - A bubble is inserted.
  - sel_err is set to 1.
- Stall (flush=0): all stages hold. Inputs are ignored, including range checking.
- Flush has priority over stall and in_valid. On the next edge all valid_k=0 and all data_k=0. The input item in that cycle is dropped and never checked.
- sel_err behaviour:
  - Set by an out-of-range accept.
  - Cleared by err_clr=1.
  - If set and clear occur on the same edge, set wins and sel_err stays 1.
  - Unaffected by flush and stall.
- occupancy is a registered count equal to the popcount of the valid bits after each edge. It changes only on edges.
- Reset (rst_n=0, asynchronous): all stage registers, out_data, out_valid, occupancy and sel_err go to 0 immediately, without waiting for a clock edge. Normal operation resumes on the first rising edge after rst_n returns high.

## Timing
- Latency: an item accepted at edge t appears on out_data/out_valid after edge t+STAGES-1, counting only accept edges. With STAGES=1 it is visible directly after the capturing edge.
- Each stall cycle adds exactly one cycle of latency to every in-flight item. No item is duplicated or lost.
- Throughput: one item per non-stalled cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- If reset is asserted mid-stream, all in-flight items are discarded.

## Test plan
(WIDTH=8, N_IN=4, STAGES=2 unless noted)
1. Reset handling:
   - Drive rst_n=0 at time 0 -> all outputs 0.
   - Pulse rst_n=0 mid-stream between clock edges -> outputs are 0 before the next edge, and occupancy is 0 after release.
2. Select sweep:
   - Set channels 0..3 = A5, 5A, FF, 12; sel=0,1,2,3 on consecutive cycles with in_valid=1.
   - Required: out_data = A5, 5A, FF, 12 on consecutive cycles, the first appearing after the 2nd accept edge.
   - Required: occupancy = 1 then 2 steady; out_valid=1 throughout.
3. Stall mid-stream:
   - Assert stall for 3 cycles while DE and BE are in flight.
   - Required: out_data and occupancy frozen during the stall.
   - Required: after release, DE then BE emerge exactly once each; input presented during the stall is ignored.
4. Flush priority:
   - Assert flush together with stall=1 and in_valid=1, with occupancy=2.
   - Required: next edge gives out_valid=0, out_data=00, occupancy=0; the flushed input never appears.
5. Range error (N_IN=3, SEL_W=2):
   - sel=3 with in_valid=1 -> bubble (out_valid=0, out_data=00 at the output slot), and sel_err=1 persists across later cycles.
   - err_clr=1 alone -> sel_err=0.
   - err_clr=1 together with a new sel=3 accept -> sel_err stays 1.
6. Bubbles:
   - Alternate in_valid 1/0 with sel=1 and channel 1 = 34.
   - Required: out_valid toggles 1/0, out_data toggles 34/00, occupancy stays at 1.
